led_pulse_multi: RTL and testbench

//   Multi-channel LED sequencer, successor to the single-channel pulse stretcher.

---
 rtl/led_pulse_multi.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_led_pulse_multi.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_pulse_multi.sv
// ---------------------------------------------------------------------------
// led_pulse_multi
//   Multi-channel LED sequencer. Each channel runs a one-shot pulse, an
//   N-pulse burst or a continuous blink. Per-channel ON/OFF/repeat settings
//   are written over a shared config port into shadow registers. A running
//   sequence keeps the copy it latched when it was triggered.
//
//   Optional feature macro: LED_PULSE_PWM_EN
//     defined   : a free-running PWM counter shared by all channels dims the
//                 LED during ON using the per-channel duty value.
//     undefined : led follows the ON phase directly; cfg_duty is ignored and
//                 no PWM counter or duty storage is built.
//
// Ports
//   clk       clock
//   rst       synchronous, active-high reset
//   trigger   per-channel start/restart (sampled every cycle)
//   stop      per-channel abort (wins over trigger)
//   cfg_we    config write strobe
//   cfg_ch    config target channel (values >= NUM_CH are ignored)
//   cfg_mode  0 ONESHOT, 1 BURST, 2 REPEAT, 3 ONESHOT
//   cfg_on    ON length in cycles (0 treated as 1)
//   cfg_off   OFF length in cycles (0 treated as 1)
//   cfg_reps  BURST pulse count (0 treated as 1)
//   cfg_duty  ON-phase dimming duty (PWM build only)
//   led       LED drive
//   busy      channel not IDLE
//   done      one-cycle pulse in the first IDLE cycle after a natural end
// ---------------------------------------------------------------------------
module led_pulse_multi #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CNT_W  = 32,
  parameter int unsigned PWM_W  = 8,
  localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] trigger,
  input  logic [NUM_CH-1:0] stop,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [1:0]        cfg_mode,
  input  logic [CNT_W-1:0]  cfg_on,
  input  logic [CNT_W-1:0]  cfg_off,
  input  logic [7:0]        cfg_reps,
  input  logic [PWM_W-1:0]  cfg_duty,
  output logic [NUM_CH-1:0] led,
  output logic [NUM_CH-1:0] busy,
  output logic [NUM_CH-1:0] done
);

  localparam int unsigned REP_W = 8;

  localparam logic [1:0] MODE_ONESHOT = 2'd0;
  localparam logic [1:0] MODE_BURST   = 2'd1;
  localparam logic [1:0] MODE_REPEAT  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2
  } state_e;

  typedef struct packed {
    logic [1:0]       mode;
    logic [CNT_W-1:0] on_len;
    logic [CNT_W-1:0] off_len;
    logic [REP_W-1:0] reps;
  } cfg_t;

  localparam cfg_t CFG_RST = '{
    mode:    MODE_ONESHOT,
    on_len:  CNT_W'(1),
    off_len: CNT_W'(1),
    reps:    REP_W'(1)
  };

  // Per-channel state
  state_e           state_q  [NUM_CH];
  state_e           state_d  [NUM_CH];
  logic [CNT_W-1:0] cnt_q    [NUM_CH];
  logic [CNT_W-1:0] cnt_d    [NUM_CH];
  logic [REP_W-1:0] rep_q    [NUM_CH];
  logic [REP_W-1:0] rep_d    [NUM_CH];
  cfg_t             shadow_q [NUM_CH];
  cfg_t             shadow_d [NUM_CH];
  cfg_t             run_q    [NUM_CH];
  cfg_t             run_d    [NUM_CH];

  cfg_t              new_cfg;
  logic [NUM_CH-1:0] cfg_hit;
  logic [NUM_CH-1:0] trig_go;
  logic [NUM_CH-1:0] nat_end;
  logic [NUM_CH-1:0] pwm_pass;

  logic [NUM_CH-1:0] led_q,  led_d;
  logic [NUM_CH-1:0] busy_q, busy_d;
  logic [NUM_CH-1:0] done_q, done_d;

  assign led  = led_q;
  assign busy = busy_q;
  assign done = done_q;

  // Config decode: sanitise incoming values and update shadows. shadow_d is
  // also what a same-cycle trigger latches, which gives the write bypass.
  always_comb begin
    new_cfg.mode    = (cfg_mode == MODE_REPEAT || cfg_mode == MODE_BURST) ? cfg_mode : MODE_ONESHOT;
    new_cfg.on_len  = (cfg_on   == '0) ? CNT_W'(1) : cfg_on;
    new_cfg.off_len = (cfg_off  == '0) ? CNT_W'(1) : cfg_off;
    new_cfg.reps    = (cfg_reps == '0) ? REP_W'(1) : cfg_reps;
    cfg_hit         = '0;
    trig_go         = '0;
    shadow_d        = shadow_q;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      cfg_hit[i] = cfg_we && (cfg_ch == CH_W'(i));
      trig_go[i] = trigger[i] && !stop[i];
      if (cfg_hit[i]) begin
        shadow_d[i] = new_cfg;
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        state_q[i] <= ST_IDLE;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        state_q[i] <= state_d[i];
      end
    end
  end

  // Datapath, config and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        cnt_q[i]    <= '0;
        rep_q[i]    <= '0;
        shadow_q[i] <= CFG_RST;
        run_q[i]    <= CFG_RST;
      end
      led_q  <= '0;
      busy_q <= '0;
      done_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        cnt_q[i]    <= cnt_d[i];
        rep_q[i]    <= rep_d[i];
        shadow_q[i] <= shadow_d[i];
        run_q[i]    <= run_d[i];
      end
      led_q  <= led_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  // Next-state: stop beats trigger, trigger restarts from any state, and the
  // phase counters count down to 1 before the phase ends.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rep_d   = rep_q;
    run_d   = run_q;
    nat_end = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (stop[i]) begin
        state_d[i] = ST_IDLE;
      end else if (trig_go[i]) begin
        state_d[i] = ST_ON;
        run_d[i]   = shadow_d[i];
        cnt_d[i]   = shadow_d[i].on_len;
        rep_d[i]   = shadow_d[i].reps;
      end else begin
        unique case (state_q[i])
          ST_ON: begin
            if (cnt_q[i] == CNT_W'(1)) begin
              case (run_q[i].mode)
                MODE_BURST: begin
                  if (rep_q[i] > REP_W'(1)) begin
                    rep_d[i]   = rep_q[i] - REP_W'(1);
                    state_d[i] = ST_OFF;
                    cnt_d[i]   = run_q[i].off_len;
                  end else begin
                    state_d[i] = ST_IDLE;
                    nat_end[i] = 1'b1;
                  end
                end
                MODE_REPEAT: begin
                  state_d[i] = ST_OFF;
                  cnt_d[i]   = run_q[i].off_len;
                end
                default: begin
                  state_d[i] = ST_IDLE;
                  nat_end[i] = 1'b1;
                end
              endcase
            end else begin
              cnt_d[i] = cnt_q[i] - CNT_W'(1);
            end
          end
          ST_OFF: begin
            if (cnt_q[i] == CNT_W'(1)) begin
              state_d[i] = ST_ON;
              cnt_d[i]   = run_q[i].on_len;
            end else begin
              cnt_d[i] = cnt_q[i] - CNT_W'(1);
            end
          end
          default: begin
            state_d[i] = ST_IDLE;
          end
        endcase
      end
    end
  end

`ifdef LED_PULSE_PWM_EN
  logic [PWM_W-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [PWM_W-1:0] duty_sh_q  [NUM_CH];
  logic [PWM_W-1:0] duty_sh_d  [NUM_CH];
  logic [PWM_W-1:0] duty_run_q [NUM_CH];
  logic [PWM_W-1:0] duty_run_d [NUM_CH];

  // Duty follows the same shadow/latch/bypass rules as the timing config.
  // The comparison uses the counter value that is live while led_q shows.
  always_comb begin
    pwm_cnt_d  = pwm_cnt_q + PWM_W'(1);
    duty_sh_d  = duty_sh_q;
    duty_run_d = duty_run_q;
    pwm_pass   = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (cfg_hit[i]) begin
        duty_sh_d[i] = cfg_duty;
      end
      if (trig_go[i]) begin
        duty_run_d[i] = duty_sh_d[i];
      end
      pwm_pass[i] = (duty_run_d[i] == '1) || (pwm_cnt_d < duty_run_d[i]);
    end
  end

  // PWM counter and duty registers
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt_q <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        duty_sh_q[i]  <= '1;
        duty_run_q[i] <= '1;
      end
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        duty_sh_q[i]  <= duty_sh_d[i];
        duty_run_q[i] <= duty_run_d[i];
      end
    end
  end
`else
  logic unused_duty;
  assign unused_duty = ^cfg_duty;
  assign pwm_pass    = '1;
`endif

  // Outputs: decoded from the next state so the registered outputs line up
  // with the state register.
  always_comb begin
    led_d  = '0;
    busy_d = '0;
    done_d = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      busy_d[i] = (state_d[i] != ST_IDLE);
      done_d[i] = nat_end[i];
      led_d[i]  = (state_d[i] == ST_ON) && pwm_pass[i];
    end
  end

endmodule

// File: tb/tb_led_pulse_multi.sv
// Bench for led_pulse_multi: directed scenarios followed by random traffic,
// all checked against a timeline model (position since trigger, arithmetic on
// on/off/reps) plus directed pattern checks.
module tb_led_pulse_multi;
  localparam int unsigned NUM_CH = 3;
  localparam int unsigned CNT_W  = 32;
  localparam int unsigned PWM_W  = 8;
  localparam int unsigned CH_W   = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NUM_CH-1:0] trigger, stop;
  logic              cfg_we;
  logic [CH_W-1:0]   cfg_ch;
  logic [1:0]        cfg_mode;
  logic [CNT_W-1:0]  cfg_on, cfg_off;
  logic [7:0]        cfg_reps;
  logic [PWM_W-1:0]  cfg_duty;
  logic [NUM_CH-1:0] led, busy, done;

  always #5 clk = ~clk;

  led_pulse_multi #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .PWM_W(PWM_W)) dut (
    .clk(clk), .rst(rst), .trigger(trigger), .stop(stop),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_mode(cfg_mode),
    .cfg_on(cfg_on), .cfg_off(cfg_off), .cfg_reps(cfg_reps), .cfg_duty(cfg_duty),
    .led(led), .busy(busy), .done(done)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state
  int unsigned sh_mode[NUM_CH], sh_on[NUM_CH], sh_off[NUM_CH], sh_reps[NUM_CH], sh_duty[NUM_CH];
  int unsigned l_mode[NUM_CH], l_on[NUM_CH], l_off[NUM_CH], l_reps[NUM_CH], l_duty[NUM_CH];
  bit          act[NUM_CH];
  int unsigned t0[NUM_CH];
  int unsigned cyc   = 0;
  int unsigned pwm_m = 0;
  logic [NUM_CH-1:0] e_led, e_busy, e_done;

  logic [31:0] lh, bh, dh;
  int          cnt;

  function automatic int unsigned nz(input int unsigned x);
    return (x == 0) ? 1 : x;
  endfunction

  function automatic bit pwm_ok(input int unsigned duty);
`ifdef LED_PULSE_PWM_EN
    return (duty == 255) || (pwm_m < duty);
`else
    return 1'b1;
`endif
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, advance the model at the edge, compare outputs.
  task automatic step(input logic [NUM_CH-1:0] trg, input logic [NUM_CH-1:0] stp,
                      input logic we, input logic [CH_W-1:0] ch, input logic [1:0] md,
                      input int unsigned on_v, input int unsigned off_v,
                      input int unsigned reps_v, input int unsigned duty_v, input logic r);
    int unsigned p, per, total;
    trigger  = trg;
    stop     = stp;
    cfg_we   = we;
    cfg_ch   = ch;
    cfg_mode = md;
    cfg_on   = CNT_W'(on_v);
    cfg_off  = CNT_W'(off_v);
    cfg_reps = 8'(reps_v);
    cfg_duty = PWM_W'(duty_v);
    rst      = r;
    @(posedge clk);
    e_led  = '0;
    e_busy = '0;
    e_done = '0;
    if (r) begin
      pwm_m = 0;
      for (int i = 0; i < NUM_CH; i++) begin
        sh_mode[i] = 0; sh_on[i] = 1; sh_off[i] = 1; sh_reps[i] = 1; sh_duty[i] = 255;
        act[i] = 1'b0;
      end
    end else begin
      pwm_m = (pwm_m + 1) % 256;
      if (we && ch < NUM_CH) begin
        sh_mode[ch] = (md == 2'd3) ? 0 : int'(md);
        sh_on[ch]   = nz(on_v);
        sh_off[ch]  = nz(off_v);
        sh_reps[ch] = nz(reps_v % 256);
        sh_duty[ch] = duty_v % 256;
      end
      for (int i = 0; i < NUM_CH; i++) begin
        if (stp[i]) begin
          act[i] = 1'b0;
        end else if (trg[i]) begin
          act[i] = 1'b1; t0[i] = cyc;
          l_mode[i] = sh_mode[i]; l_on[i] = sh_on[i]; l_off[i] = sh_off[i];
          l_reps[i] = sh_reps[i]; l_duty[i] = sh_duty[i];
        end
        if (act[i]) begin
          p     = cyc - t0[i];
          per   = l_on[i] + l_off[i];
          total = (l_mode[i] == 1) ? l_reps[i] * l_on[i] + (l_reps[i] - 1) * l_off[i] : l_on[i];
          if (l_mode[i] == 2 || p < total) begin
            e_busy[i] = 1'b1;
            e_led[i]  = ((p % per) < l_on[i]) && pwm_ok(l_duty[i]);
          end else begin
            e_done[i] = 1'b1;
            act[i]    = 1'b0;
          end
        end
      end
    end
    cyc++;
    #1;
    chk("led",  led,  e_led);
    chk("busy", busy, e_busy);
    chk("done", done, e_done);
  endtask

  task automatic idle();
    step('0, '0, 1'b0, '0, 2'd0, 0, 0, 0, 255, 1'b0);
  endtask

  task automatic wr(input logic [CH_W-1:0] ch, input logic [1:0] md, input int unsigned on_v,
                    input int unsigned off_v, input int unsigned reps_v, input int unsigned duty_v);
    step('0, '0, 1'b1, ch, md, on_v, off_v, reps_v, duty_v, 1'b0);
  endtask

  task automatic trg(input logic [NUM_CH-1:0] m);
    step(m, '0, 1'b0, '0, 2'd0, 0, 0, 0, 255, 1'b0);
  endtask

  // Sample channel ch now, then for n-1 further idle cycles.
  task automatic collect(input int ch, input int n);
    lh = '0; bh = '0; dh = '0;
    for (int k = 0; k < n; k++) begin
      if (k > 0) idle();
      lh[k] = led[ch]; bh[k] = busy[ch]; dh[k] = done[ch];
    end
  endtask

  initial begin
    logic [NUM_CH-1:0] tm, sm;
    int unsigned       dv;

    step('0, '0, 1'b0, '0, 2'd0, 0, 0, 0, 0, 1'b1);
    step('0, '0, 1'b0, '0, 2'd0, 0, 0, 0, 0, 1'b1);
    chk("reset_outputs", {led, busy, done}, '0);

    // ONESHOT on=5
    wr(2'd0, 2'd0, 5, 1, 1, 255);
    trg(3'b001);
    collect(0, 8);
    chk("t1_led",  lh[7:0], 8'h1F);
    chk("t1_busy", bh[7:0], 8'h1F);
    chk("t1_done", dh[7:0], 8'h20);

    // BURST on=3 off=2 reps=3
    wr(2'd1, 2'd1, 3, 2, 3, 255);
    trg(3'b010);
    collect(1, 16);
    chk("t2_led",  lh[15:0], 16'h1CE7);
    chk("t2_busy", bh[15:0], 16'h1FFF);
    chk("t2_done", dh[15:0], 16'h2000);

    // ONESHOT on=10, retrigger 4 cycles in
    wr(2'd2, 2'd0, 10, 1, 1, 255);
    lh = '0; bh = '0; dh = '0;
    for (int k = 0; k < 16; k++) begin
      if (k == 0 || k == 4) trg(3'b100); else idle();
      lh[k] = led[2]; bh[k] = busy[2]; dh[k] = done[2];
    end
    chk("t3_led",  lh[15:0], 16'h3FFF);
    chk("t3_busy", bh[15:0], 16'h3FFF);
    chk("t3_done", dh[15:0], 16'h4000);

    // REPEAT on=2 off=2, then stop+trigger together
    wr(2'd0, 2'd2, 2, 2, 1, 255);
    trg(3'b001);
    for (int k = 0; k < 5; k++) idle();
    step(3'b001, 3'b001, 1'b0, '0, 2'd0, 0, 0, 0, 255, 1'b0);
    chk("t4_stop_led",  led[0],  1'b0);
    chk("t4_stop_busy", busy[0], 1'b0);
    cnt = 0;
    for (int k = 0; k < 4; k++) begin idle(); cnt += int'(done[0]); end
    chk("t4_no_done", cnt, 0);

    // Config write and trigger in the same cycle (bypass)
    step(3'b010, '0, 1'b1, 2'd1, 2'd0, 7, 1, 1, 255, 1'b0);
    collect(1, 8);
    chk("t4_bypass_led",  lh[7:0], 8'h7F);
    chk("t4_bypass_done", dh[7:0], 8'h80);

    // Reset in the middle of a burst; defaults restored
    wr(2'd1, 2'd1, 3, 2, 3, 255);
    trg(3'b010);
    for (int k = 0; k < 4; k++) idle();
    step('0, '0, 1'b0, '0, 2'd0, 0, 0, 0, 255, 1'b1);
    chk("t5_reset", {led, busy, done}, '0);
    trg(3'b010);
    collect(1, 3);
    chk("t5_led",  lh[2:0], 3'b001);
    chk("t5_done", dh[2:0], 3'b010);

    // Out-of-range write ignored; simultaneous triggers all honoured
    wr(2'd3, 2'd0, 9, 9, 9, 255);
    trg(3'b111);
    chk("oor_led", led, 3'b111);
    idle();
    chk("oor_done", done, 3'b111);
    chk("oor_led_off", led, 3'b000);

    // Held trigger keeps led high
    for (int k = 0; k < 5; k++) begin
      trg(3'b001);
      chk("held_led", led[0], 1'b1);
    end
    idle();
    chk("held_end_done", done[0], 1'b1);

    // Dimming: duty=64, on=1024
    wr(2'd2, 2'd0, 1024, 1, 1, 64);
    trg(3'b100);
    cnt = 0;
    for (int k = 0; k < 1024; k++) begin
      if (k > 0) idle();
      cnt += int'(led[2]);
    end
`ifdef LED_PULSE_PWM_EN
    chk("t6_led_count", cnt, 256);
`else
    chk("t6_led_count", cnt, 1024);
`endif
    idle();
    chk("t6_done", done[2], 1'b1);

    // Random traffic against the model
    step('0, '0, 1'b0, '0, 2'd0, 0, 0, 0, 255, 1'b1);
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < NUM_CH; i++) begin
        tm[i] = ($urandom_range(5) == 0);
        sm[i] = ($urandom_range(24) == 0);
      end
      case ($urandom_range(2))
        0:       dv = 255;
        1:       dv = 0;
        default: dv = $urandom_range(255);
      endcase
      step(tm, sm, ($urandom_range(3) == 0), CH_W'($urandom_range(3)), 2'($urandom_range(3)),
           $urandom_range(6), $urandom_range(6), $urandom_range(4), dv,
           ($urandom_range(499) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
